uart_rx: RTL and testbench

Single-clock UART receiver with a receive buffer. It samples serial rx_i at mid-bit using a runtime-programmable bit period and deframes 8N1 frames, LSB first. Received bytes go into an internal first-word-fall-through buffer that the host drains through a pop/empty interface. It is the receive counterpart of the existing uart_tx and sits beside it in the UART peripheral.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that samples each bit mid-period and feeds a first-word-fall-through receive buffer.
// Define UART_RX_FERR_EN to add the framing-error pulse (ferr_o) and the break detector (brk_o).
module uart_rx #(
    parameter int unsigned BUFSZ                  = 2,
    parameter int unsigned CLOCKCYCLESPERBITLIMIT = 2,
    localparam int unsigned CW = $clog2(CLOCKCYCLESPERBITLIMIT),
    localparam int unsigned AW = $clog2(BUFSZ)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CW-1:0] clockcyclesperbit_i,
    input  logic          rx_i,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          empty_o,
    output logic [AW:0]   usage_o,
`ifdef UART_RX_FERR_EN
    output logic          ferr_o,
    output logic          brk_o,
`endif
    output logic          ovr_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic          rx_meta, rxs;
    logic [CW-1:0] p_q, p_d, cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          commit;

    logic [7:0]    mem [BUFSZ];
    logic [AW:0]   wptr, rptr;
    logic          full, empty, do_push, do_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            p_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    p_d     = clockcyclesperbit_i;
                    cnt_d   = clockcyclesperbit_i >> 1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = p_q - CW'(1);
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    sh_d  = {rxs, sh_q[7:1]};
                    cnt_d = p_q - CW'(1);
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // a line still held low after a bad stop bit must not look like a new start
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = commit && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            ovr_o <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
            ovr_o <= commit && full && !pop_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= sh_q;
    end

    assign empty_o = empty;
    assign usage_o = wptr - rptr;
    assign data_o  = empty ? '0 : mem[rptr[AW-1:0]];

`ifdef UART_RX_FERR_EN
    localparam int unsigned BW = CW + 4;
    logic [BW-1:0] brk_cnt, brk_limit;

    assign brk_limit = BW'(p_q) * BW'(10);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ferr_o  <= 1'b0;
            brk_cnt <= '0;
        end else begin
            ferr_o <= (state_q == STOP) && (cnt_q == '0) && !rxs;
            // consecutive low cycles; a start edge is the first of them
            if (rxs)                brk_cnt <= '0;
            else if (brk_cnt != '1) brk_cnt <= brk_cnt + BW'(1);
        end
    end

    assign brk_o = !rxs && (p_q != '0) && (brk_cnt >= brk_limit);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a queue-based model of the receive buffer.
module tb_uart_rx;
    localparam int unsigned BUFSZ = 2;
    localparam int unsigned LIM   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cpb = 5'd16;
    logic       rx  = 1'b1;
    logic       pop = 1'b0;
    logic [7:0] data;
    logic       empty;
    logic [1:0] usage;
    logic       ovr;
`ifdef UART_RX_FERR_EN
    logic       ferr, brk;
`endif

    uart_rx #(.BUFSZ(BUFSZ), .CLOCKCYCLESPERBITLIMIT(LIM)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .clockcyclesperbit_i(cpb),
        .rx_i(rx),
        .pop_i(pop),
        .data_o(data),
        .empty_o(empty),
        .usage_o(usage),
`ifdef UART_RX_FERR_EN
        .ferr_o(ferr),
        .brk_o(brk),
`endif
        .ovr_o(ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_seen = 0, exp_ovr  = 0;
    int ferr_seen = 0, exp_ferr = 0;
    byte unsigned model_q[$];

    always @(negedge clk) if (ovr === 1'b1) ovr_seen++;
`ifdef UART_RX_FERR_EN
    always @(negedge clk) if (ferr === 1'b1) ferr_seen++;
`endif

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line-level frame: start 0, eight data bits LSB first, stop bit; cpb is scrambled mid-frame.
    task automatic send_frame(input byte unsigned b, input int p, input bit stop);
        logic [9:0] f;
        f   = {stop, b, 1'b0};
        cpb = 5'(p);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (p) @(posedge clk);
            #1;
            if (i == 0) cpb = 5'($urandom_range(4, LIM - 1));
        end
        rx = 1'b1;
    endtask

    task automatic model_frame(input byte unsigned b, input bit stop_ok);
        if (!stop_ok) exp_ferr++;
        else if (model_q.size() < BUFSZ) model_q.push_back(b);
        else exp_ovr++;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_usage"}, 32'(usage), 32'(model_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_ovr"}, 32'(ovr_seen), 32'(exp_ovr));
`ifdef UART_RX_FERR_EN
        check({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
`endif
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_nonempty"}, 32'(empty), 32'd0);
        check({tag, "_data"}, 32'(data), 32'(model_q[0]));
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        void'(model_q.pop_front());
    endtask

    initial begin
        int p, nf, np;
        byte unsigned b;
        bit stop_ok;

        idle(3);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_usage", 32'(usage), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rst = 1'b0;
        idle(2);

        // single frame, then pop to empty
        send_frame(8'hA5, 16, 1'b1);
        model_frame(8'hA5, 1'b1);
        idle(4);
        check_state("a5");
        pop_check("a5_pop");
        check("a5_after_pop_empty", 32'(empty), 32'd1);

        // quarter-bit glitch is a false start
        cpb = 5'd16;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check_state("glitch");

        // three back-to-back frames into a two-entry buffer
        send_frame(8'h01, 8, 1'b1); model_frame(8'h01, 1'b1);
        send_frame(8'h02, 8, 1'b1); model_frame(8'h02, 1'b1);
        send_frame(8'h03, 8, 1'b1); model_frame(8'h03, 1'b1);
        idle(4);
        check_state("b2b");
        pop_check("b2b_pop1");
        pop_check("b2b_pop2");

        // full buffer with a pop in the commit cycle of 0x55
        send_frame(8'h10, 8, 1'b1); model_frame(8'h10, 1'b1);
        send_frame(8'h20, 8, 1'b1); model_frame(8'h20, 1'b1);
        idle(4);
        check_state("full");
        fork
            send_frame(8'h55, 8, 1'b1);
            begin
                repeat (3 + 4 + 9 * 8) @(posedge clk);
                #1;
                check("simul_head", 32'(data), 32'h10);
                pop = 1'b1;
                @(posedge clk);
                #1;
                pop = 1'b0;
            end
        join
        void'(model_q.pop_front());
        model_q.push_back(8'h55);
        idle(4);
        check_state("simul");
        pop_check("simul_pop1");
        pop_check("simul_pop2");

        // framing error, then a good frame
        send_frame(8'h3C, 10, 1'b0);
        model_frame(8'h3C, 1'b0);
        idle(30);
        check_state("ferr");
        send_frame(8'h7E, 10, 1'b1);
        model_frame(8'h7E, 1'b1);
        idle(4);
        check_state("after_ferr");
        pop_check("after_ferr_pop");

        // line held low: framing error and break, no push
        cpb = 5'd8;
        rx = 1'b0;
        idle(11 * 8);
`ifdef UART_RX_FERR_EN
        check("brk_high", 32'(brk), 32'd1);
`endif
        rx = 1'b1;
        model_frame(8'h00, 1'b0);
        idle(6);
`ifdef UART_RX_FERR_EN
        check("brk_low", 32'(brk), 32'd0);
`endif
        idle(20);
        check_state("hold_low");

        // reset during data bit 4; remaining bits of 0xF5 keep the line high
        send_frame(8'h11, 12, 1'b1);
        model_frame(8'h11, 1'b1);
        idle(4);
        check_state("pre_rst");
        fork
            send_frame(8'hF5, 12, 1'b1);
            begin
                repeat (12 * 5 + 6) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("midrst_empty", 32'(empty), 32'd1);
                check("midrst_usage", 32'(usage), 32'd0);
                rst = 1'b0;
            end
        join
        model_q.delete();
        idle(30);
        check_state("post_rst");
        send_frame(8'hC3, 12, 1'b1);
        model_frame(8'hC3, 1'b1);
        idle(4);
        check_state("c3");
        pop_check("c3_pop");

        // randomized batches of frames with random bit periods, bad stops and pops
        for (int it = 0; it < 30; it++) begin
            p  = $urandom_range(4, LIM - 1);
            nf = $urandom_range(1, 3);
            for (int k = 0; k < nf; k++) begin
                b       = 8'($urandom);
                stop_ok = ($urandom_range(0, 7) != 0);
                send_frame(b, p, stop_ok);
                model_frame(b, stop_ok);
                if (!stop_ok) idle(2 * p);
            end
            idle(8);
            check_state("rand");
            np = $urandom_range(0, model_q.size());
            for (int k = 0; k < np; k++) pop_check("rand_pop");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
